// File: rtl/fp_div_sequencer.sv
// Issue/return sequencer for a multi-cycle FP divider: credit-limited issue,
// in-order result FIFO, sticky error flags and wrapping issue/completion counts.
module fp_div_sequencer #(
  parameter int RES_DEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  output logic        div_start,
  input  logic [31:0] div_result,
  input  logic        result_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  input  logic        err_clear,
  output logic        err_div_zero,
  output logic        err_spurious,
  output logic        err_timeout,
  output logic [15:0] issued_count,
  output logic [15:0] completed_count
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RES_DEPTH);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic          run;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem [RES_DEPTH];
  logic [TW-1:0] tmo_cnt;
  logic [CW:0]   credit_used;
  logic          accept, push, pop, spurious, div_zero, tmo_idle, tmo_hit;

  // run keeps op_ready low until the first edge after reset release
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign op_ready    = run && (credit_used < DEPTH_C) && !err_timeout;
  assign accept      = op_valid && op_ready;
  assign push        = result_ready && (inflight != '0);
  assign spurious    = result_ready && (inflight == '0);
  assign res_valid   = (fifo_cnt != '0);
  assign pop         = res_valid && res_ready;
  assign res_data    = res_valid ? mem[rd_ptr] : '0;
  assign div_zero    = accept && (op_b[30:0] == '0);
  assign tmo_idle    = result_ready || (inflight == '0);
  assign tmo_hit     = !tmo_idle && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= div_result;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run             <= 1'b0;
      div_start       <= 1'b0;
      dividend        <= '0;
      divisor         <= '0;
      inflight        <= '0;
      fifo_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tmo_cnt         <= '0;
      err_div_zero    <= 1'b0;
      err_spurious    <= 1'b0;
      err_timeout     <= 1'b0;
      issued_count    <= '0;
      completed_count <= '0;
    end else begin
      run       <= 1'b1;
      div_start <= accept;
      if (accept) begin
        dividend     <= op_a;
        divisor      <= op_b;
        issued_count <= issued_count + 16'd1;
      end

      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        completed_count <= completed_count + 16'd1;
      end

      // a flag-setting event in the same cycle as err_clear keeps the flag set
      if (tmo_idle)                tmo_cnt <= '0;
      else if (tmo_hit)            tmo_cnt <= TMO_MAX;
      else if (err_clear)          tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);

      err_timeout  <= tmo_hit  || (err_timeout  && !err_clear);
      err_spurious <= spurious || (err_spurious && !err_clear);
      err_div_zero <= div_zero || (err_div_zero && !err_clear);
    end
  end
endmodule

// File: tb/tb_fp_div_sequencer.sv
// Self-checking bench for fp_div_sequencer with a latency-4 divider model and
// an in-order scoreboard of expected quotients.
module tb_fp_div_sequencer;
  logic        clock = 1'b0;
  logic        reset_n, op_valid, res_ready, err_clear, spur;
  logic [31:0] op_a, op_b;
  logic        op_ready, div_start, result_ready, res_valid;
  logic        err_div_zero, err_spurious, err_timeout;
  logic [31:0] dividend, divisor, div_result, res_data;
  logic [15:0] issued_count, completed_count;

  always #5 clock = ~clock;

  fp_div_sequencer #(.RES_DEPTH(8), .TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dividend(dividend), .divisor(divisor), .div_start(div_start),
    .div_result(div_result), .result_ready(result_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_clear(err_clear), .err_div_zero(err_div_zero),
    .err_spurious(err_spurious), .err_timeout(err_timeout),
    .issued_count(issued_count), .completed_count(completed_count)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] q; logic dz; } vec_t;
  typedef struct { int idx; logic [31:0] q; } sb_t;
  localparam int NV = 8;
  vec_t vecs [NV];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, iss_n = 0, drop_idx = -1, last_rr = 0;
  int acc_n = 0, accepted = 0, pops = 0;
  bit dropped [int];
  sb_t sb [$];
  logic [3:0]  pv = '0;
  logic [31:0] pd [4];
  logic        m_ok;
  sb_t         m_e;

  // true IEEE quotients for the table pairs, an arbitrary mix otherwise
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NV; i++)
      if (vecs[i].a == a && vecs[i].b == b) return vecs[i].q;
    return a ^ {b[7:0], b[31:8]} ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_flush();
    sb.delete();
    acc_n = iss_n;
    accepted = 0;
    pops = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0; err_clear = 1'b0; spur = 1'b0;
    repeat (2) tick();
    sb_flush();
    reset_n = 1'b1;
    tick();
  endtask

  // divider model: quotient and result_ready exactly 4 cycles after div_start
  assign result_ready = pv[3] | spur;
  assign div_result   = pd[3];
  initial forever begin
    @(posedge clock);
    m_ok = 1'b0;
    if (div_start) begin
      if (iss_n == drop_idx) dropped[iss_n] = 1'b1;
      else m_ok = 1'b1;
      iss_n = iss_n + 1;
    end
    if (pv[3]) last_rr <= cyc;
    cyc   <= cyc + 1;
    pv    <= {pv[2:0], m_ok};
    pd[0] <= quot(dividend, divisor);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  // scoreboard: accepted ops in order, compared on every downstream pop
  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      if (op_valid && op_ready) begin
        sb.push_back('{acc_n, quot(op_a, op_b)});
        acc_n++;
        accepted++;
      end
      if (res_valid && res_ready) begin
        while (sb.size() > 0 && dropped.exists(sb[0].idx)) void'(sb.pop_front());
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got 0x%08h want no result", res_data);
        end else begin
          m_e = sb.pop_front();
          check32("sb_order", res_data, m_e.q);
        end
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bqa [20];
    logic [31:0] bqb [20];
    int k, c, p0, el;
    logic r;

    vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
    vecs[1] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0};
    vecs[2] = '{32'h4100_0000, 32'hC080_0000, 32'hC000_0000, 1'b0};
    vecs[3] = '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 1'b1};
    vecs[4] = '{32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1};
    vecs[5] = '{32'h42C8_0000, 32'h4120_0000, 32'h4120_0000, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h3F80_0000, 32'h8000_0001, 32'hFF80_0000, 1'b0};

    reset_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    res_ready = 1'b0; err_clear = 1'b0; spur = 1'b0;
    repeat (3) tick();
    check1("rst_op_ready", op_ready, 1'b0);
    check1("rst_div_start", div_start, 1'b0);
    check32("rst_dividend", dividend, 32'h0);
    check32("rst_divisor", divisor, 32'h0);
    check1("rst_res_valid", res_valid, 1'b0);
    check32("rst_res_data", res_data, 32'h0);
    check32("rst_errs", {29'h0, err_div_zero, err_spurious, err_timeout}, 32'h0);
    check32("rst_counts", {issued_count, completed_count}, 32'h0);
    reset_n = 1'b1;
    #1;
    check1("ready_before_edge", op_ready, 1'b0);
    tick();
    check1("ready_after_edge", op_ready, 1'b1);

    // single op: strobe at T+1, result visible at T+6
    op_valid = 1'b1; op_a = 32'h40C0_0000; op_b = 32'h4000_0000;
    tick();
    op_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    check1("t1_div_start", div_start, 1'b1);
    check32("t1_dividend", dividend, 32'h40C0_0000);
    check32("t1_divisor", divisor, 32'h4000_0000);
    tick();
    check1("t2_div_start", div_start, 1'b0);
    check32("t2_dividend_hold", dividend, 32'h40C0_0000);
    repeat (3) tick();
    check1("t5_res_valid", res_valid, 1'b0);
    tick();
    check1("t6_res_valid", res_valid, 1'b1);
    check32("t6_res_data", res_data, 32'h4040_0000);
    tick();
    check32("t7_res_data_hold", res_data, 32'h4040_0000);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check1("single_popped", res_valid, 1'b0);
    check32("single_counts", {issued_count, completed_count}, {16'd1, 16'd1});

    for (int i = 0; i < NV; i++) begin
      op_valid = 1'b1; op_a = vecs[i].a; op_b = vecs[i].b; res_ready = 1'b1;
      tick();
      op_valid = 1'b0;
      c = 0;
      while (!res_valid && c < 20) begin tick(); c++; end
      check1($sformatf("vec%0d_valid", i), res_valid, 1'b1);
      check32($sformatf("vec%0d_q", i), res_data, vecs[i].q);
      check1($sformatf("vec%0d_dz", i), err_div_zero, vecs[i].dz);
      tick();
      res_ready = 1'b0;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check1($sformatf("vec%0d_dz_clr", i), err_div_zero, 1'b0);
    end

    // -0 divisor accepted in the same cycle as err_clear: the flag must stick
    op_valid = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h8000_0000; err_clear = 1'b1;
    tick();
    op_valid = 1'b0; err_clear = 1'b0;
    check1("dz_set_wins", err_div_zero, 1'b1);
    check1("dz_issued", div_start, 1'b1);
    res_ready = 1'b1;
    c = 0;
    while (!res_valid && c < 20) begin tick(); c++; end
    check32("dz_result", res_data, 32'hFF80_0000);
    tick();
    res_ready = 1'b0;

    // backpressure: 20 offered, only RES_DEPTH get in until the FIFO drains
    for (int i = 0; i < 20; i++) begin bqa[i] = $urandom; bqb[i] = $urandom; end
    p0 = pops;
    k = 0;
    for (int j = 0; j < 30; j++) begin
      op_valid = 1'b1; op_a = bqa[k]; op_b = bqb[k]; r = op_ready;
      tick();
      if (r) k++;
    end
    op_valid = 1'b0;
    check32("bp_accepted", k, 32'd8);
    check1("bp_op_ready", op_ready, 1'b0);
    res_ready = 1'b1;
    c = 0;
    while (k < 20 && c < 300) begin
      op_valid = 1'b1; op_a = bqa[k]; op_b = bqb[k]; r = op_ready;
      tick();
      if (r) k++;
      c++;
    end
    op_valid = 1'b0;
    c = 0;
    while (pops < p0 + 20 && c < 300) begin tick(); c++; end
    check32("bp_all_out", pops - p0, 32'd20);
    res_ready = 1'b0;

    // lost result: the fourth op never returns
    drop_idx = iss_n + 3;
    res_ready = 1'b1;
    k = 0; c = 0;
    while (k < 5 && c < 50) begin
      op_valid = 1'b1; op_a = $urandom; op_b = $urandom | 32'h3F80_0000; r = op_ready;
      tick();
      if (r) k++;
      c++;
    end
    op_valid = 1'b0;
    c = 0;
    while (!err_timeout && c < 200) begin tick(); c++; end
    el = cyc - last_rr;
    // 64 idle cycles counted after the last result, flag visible one cycle later
    check32("tmo_elapsed", el, 32'd65);
    check1("tmo_op_ready", op_ready, 1'b0);
    check1("tmo_drained", res_valid, 1'b0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check1("tmo_cleared", err_timeout, 1'b0);
    check1("tmo_ready_back", op_ready, 1'b1);
    res_ready = 1'b0;

    do_reset();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    check1("spur_flag", err_spurious, 1'b1);
    check1("spur_no_valid", res_valid, 1'b0);
    check32("spur_counts", {issued_count, completed_count}, 32'h0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check1("spur_cleared", err_spurious, 1'b0);

    // reset with 2 buffered and 3 in flight
    op_valid = 1'b1; op_a = 32'h4000_0000; op_b = 32'h3F80_0000; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    op_a = 32'h4080_0000;
    tick();
    op_valid = 1'b0;
    repeat (8) tick();
    check1("mid_buffered", res_valid, 1'b1);
    op_valid = 1'b1;
    repeat (3) tick();
    op_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check1("mid_rst_res_valid", res_valid, 1'b0);
    check1("mid_rst_op_ready", op_ready, 1'b0);
    #1;
    sb_flush();
    reset_n = 1'b1;
    repeat (10) tick();
    check1("late_spurious", err_spurious, 1'b1);
    check1("late_no_dz", err_div_zero, 1'b0);
    check1("late_no_tmo", err_timeout, 1'b0);
    check1("late_no_valid", res_valid, 1'b0);
    check32("late_counts", {issued_count, completed_count}, 32'h0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // random traffic against the scoreboard
    for (int j = 0; j < 400; j++) begin
      op_valid  = ($urandom_range(0, 3) != 0);
      op_a      = $urandom;
      op_b      = $urandom | 32'h0080_0000;
      res_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    c = 0;
    while ((pops < accepted || res_valid) && c < 300) begin tick(); c++; end
    check32("rnd_drain", pops, accepted);
    check32("rnd_issued", {16'h0, issued_count}, accepted & 32'hFFFF);
    check32("rnd_completed", {16'h0, completed_count}, accepted & 32'hFFFF);
    check32("rnd_sb_empty", sb.size(), 32'd0);
    check1("rnd_no_spur", err_spurious, 1'b0);
    check1("rnd_no_tmo", err_timeout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_div_sequencer.md
FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

Interface
REQ-001 Parameter RES_DEPTH, default 8, result FIFO depth and max in-flight-plus-buffered ops; power of 2, range 2..64.
REQ-002 Parameter TIMEOUT, default 64, max cycles with ops outstanding and no divider result before a timeout error.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 op_valid  in  1  operand pair offered.
REQ-006 op_ready  out  1  operand pair accepted when op_valid && op_ready.
REQ-007 op_a  in  32  IEEE-754 single dividend.
REQ-008 op_b  in  32  IEEE-754 single divisor.
REQ-009 dividend  out  32  to divider.
REQ-010 divisor  out  32  to divider.
REQ-011 div_start  out  1  one-cycle issue strobe to divider.
REQ-012 div_result  in  32  divider quotient.
REQ-013 result_ready  in  1  divider quotient valid, one cycle per op, no backpressure.
REQ-014 res_valid  out  1  quotient available downstream.
REQ-015 res_ready  in  1  downstream takes quotient when res_valid && res_ready.
REQ-016 res_data  out  32  quotient, issue order.
REQ-017 err_clear  in  1  clears sticky error flags.
REQ-018 err_div_zero  out  1  sticky: accepted op_b had exponent and mantissa all zero (+/-0).
REQ-019 err_spurious  out  1  sticky: result_ready seen with zero ops in flight.
REQ-020 err_timeout  out  1  sticky: TIMEOUT expired.
REQ-021 issued_count, completed_count  out  16 each  wrapping counts of div_start pulses and FIFO pops.

Function
REQ-022 inflight: ops accepted but result not yet received; fifo_cnt: quotients buffered.
REQ-023 op_ready = (inflight + fifo_cnt < RES_DEPTH) && !err_timeout, combinational from registers only, never from op_valid.
REQ-024 On accept at cycle T: dividend/divisor register op_a/op_b, div_start = 1 in cycle T+1 only; back-to-back accepts give back-to-back strobes.
REQ-025 dividend/divisor hold last issued values while div_start = 0.
REQ-026 inflight +1 on accept, -1 on result_ready with inflight > 0; both same cycle = unchanged.
REQ-027 result_ready with inflight > 0 writes div_result into FIFO; credit rule guarantees FIFO never overflows.
REQ-028 result_ready with inflight = 0: data dropped, err_spurious set, counters unchanged.
REQ-029 FIFO first-word-fall-through on registered storage: res_valid earliest in cycle after result_ready; res_data stable while res_valid && !res_ready.
REQ-030 Pop and push same cycle: fifo_cnt unchanged, order preserved; push into empty FIFO still needs one cycle before res_valid.
REQ-031 Timeout counter resets on result_ready or inflight = 0, else increments; on reaching TIMEOUT sets err_timeout and holds; accepts blocked, buffered results still drain.
REQ-032 err_clear clears all three flags and timeout counter next cycle; a same-cycle set event wins over clear.
REQ-033 err_div_zero set on accept of +/-0 divisor; op still issued.
REQ-034 Pointers and counters wrap modulo their width without flags.

Reset
REQ-035 reset_n low asynchronously forces: op_ready 0, div_start 0, dividend 0, divisor 0, res_valid 0, res_data 0, all err flags 0, both counts 0, inflight 0, FIFO empty, timeout counter 0.
REQ-036 Reset mid-operation discards in-flight and buffered ops; divider results arriving after reset release count as spurious.
REQ-037 op_ready rises first rising edge after reset_n deasserts.

Verification (divider model latency 4, RES_DEPTH 8, TIMEOUT 64)
REQ-038 Single op 0x40C00000 / 0x40000000 accepted at T -> div_start at T+1, res_valid at T+6 with res_data 0x40400000, counts 1/1 after pop.
REQ-039 20 back-to-back ops, res_ready held 0 -> exactly 8 accepted, op_ready 0; then res_ready 1 -> all 20 out in order, no loss.
REQ-040 Model drops result of op 3 -> err_timeout at 64 cycles after last result, op_ready 0; err_clear -> flag 0, op_ready 1.
REQ-041 result_ready pulse with nothing issued -> err_spurious 1, res_valid stays 0.
REQ-042 op_b = 0x80000000 -> err_div_zero 1, op still issued, result delivered.
REQ-043 reset_n low with 3 in flight, 2 buffered -> res_valid 0 immediately; 3 late results set err_spurious only.
